// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the I2C arbiter.
// slave = arbiter view, master = system logic / controller view.
interface i2c_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [7*NUM_REQ-1:0]  req_addr;
    logic [8*NUM_REQ-1:0]  req_reg;
    logic [NUM_REQ-1:0]    req_rw;
    logic [16*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [NUM_REQ-1:0]    err;
    logic [15:0]           rdata;
    logic [1:0]            mode_cfg;
    logic                  i2c_en;
    logic [1:0]            i2c_mode;
    logic [6:0]            i2c_addr;
    logic [7:0]            i2c_reg;
    logic                  i2c_rw;
    logic [15:0]           i2c_din;
    logic [15:0]           i2c_dout;
    logic                  i2c_busy;

    modport slave (
        input  req, req_addr, req_reg, req_rw, req_wdata, mode_cfg, i2c_dout, i2c_busy,
        output gnt, done, err, rdata, i2c_en, i2c_mode, i2c_addr, i2c_reg, i2c_rw, i2c_din
    );

    modport master (
        output req, req_addr, req_reg, req_rw, req_wdata, mode_cfg, i2c_dout, i2c_busy,
        input  gnt, done, err, rdata, i2c_en, i2c_mode, i2c_addr, i2c_reg, i2c_rw, i2c_din
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C controller among NUM_REQ requesters;
// sequences one bus pass for writes and two (pointer write, data read) for reads.
module i2c_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input logic          clk,
    input logic          rst,
    i2c_arbiter_if.slave bus
);
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, START, RUN, DONE, ABORT} state_t;

    state_t          state;
    logic            busy_m, busy_s, busy_p;
    logic            rise, fall, tmo;
    logic [15:0]     wcnt;
    logic [1:0]      passes;
    logic [OW-1:0]   owner, last_owner, win;

    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int unsigned k);
        int unsigned t;
        t = (32'(base) + 32'd1 + k) % NUM_REQ;
        return t[OW-1:0];
    endfunction

    assign rise = busy_s & ~busy_p;
    assign fall = ~busy_s & busy_p;
    assign tmo  = (wcnt == 16'(TIMEOUT));
    assign bus.i2c_mode = bus.mode_cfg;

    // Scan lowest priority first so the highest-priority asserted request is the last write.
    always_comb begin
        win = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (bus.req[rr_idx(last_owner, NUM_REQ - 1 - k)]) begin
                win = rr_idx(last_owner, NUM_REQ - 1 - k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy_m       <= 1'b0;
            busy_s       <= 1'b0;
            busy_p       <= 1'b0;
            wcnt         <= '0;
            passes       <= '0;
            owner        <= '0;
            last_owner   <= OW'(NUM_REQ - 1);
            bus.gnt      <= '0;
            bus.done     <= '0;
            bus.err      <= '0;
            bus.rdata    <= '0;
            bus.i2c_en   <= 1'b0;
            bus.i2c_addr <= '0;
            bus.i2c_reg  <= '0;
            bus.i2c_rw   <= 1'b0;
            bus.i2c_din  <= '0;
        end else begin
            busy_m   <= bus.i2c_busy;
            busy_s   <= busy_m;
            busy_p   <= busy_s;
            bus.done <= '0;
            bus.err  <= '0;
            case (state)
                IDLE: begin
                    bus.i2c_en <= 1'b0;
                    bus.gnt    <= '0;
                    wcnt       <= '0;
                    if (|bus.req) begin
                        owner        <= win;
                        bus.gnt      <= ONE << win;
                        bus.i2c_addr <= bus.req_addr[7*int'(win) +: 7];
                        bus.i2c_reg  <= bus.req_reg[8*int'(win) +: 8];
                        bus.i2c_rw   <= bus.req_rw[win];
                        bus.i2c_din  <= bus.req_wdata[16*int'(win) +: 16];
                        passes       <= bus.req_rw[win] ? 2'd2 : 2'd1;
                        state        <= START;
                    end
                end
                START: begin
                    bus.i2c_en <= 1'b1;
                    if (rise) begin
                        wcnt  <= '0;
                        state <= RUN;
                    end else if (tmo) begin
                        // err fires on ABORT entry so it lands TIMEOUT+1 cycles after the last restart
                        bus.i2c_en     <= 1'b0;
                        bus.err[owner] <= 1'b1;
                        wcnt           <= '0;
                        state          <= ABORT;
                    end else if (fall) begin
                        wcnt <= '0;
                    end else if (wcnt != '1) begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                RUN: begin
                    if (fall) begin
                        wcnt <= '0;
                        if (passes == 2'd1) begin
                            passes     <= '0;
                            bus.i2c_en <= 1'b0;
                            state      <= DONE;
                        end else begin
                            passes <= passes - 2'd1;
                            state  <= START;
                        end
                    end else if (tmo) begin
                        bus.i2c_en     <= 1'b0;
                        bus.err[owner] <= 1'b1;
                        wcnt           <= '0;
                        state          <= ABORT;
                    end else if (rise) begin
                        wcnt <= '0;
                    end else if (wcnt != '1) begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                DONE: begin
                    if (bus.i2c_rw) begin
                        bus.rdata <= bus.i2c_dout;
                    end
                    bus.done[owner] <= 1'b1;
                    bus.gnt         <= '0;
                    last_owner      <= owner;
                    wcnt            <= '0;
                    state           <= IDLE;
                end
                ABORT: begin
                    bus.i2c_en <= 1'b0;
                    bus.gnt    <= '0;
                    last_owner <= owner;
                    wcnt       <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed + randomized bench for i2c_arbiter with a behavioural controller model
// and a round-robin reference model.
module tb_i2c_arbiter;
    localparam int N   = 4;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_arbiter_if #(.NUM_REQ(N)) bus ();
    i2c_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit ctrl_live = 1'b1;
    int busy_len  = 6;
    int pass_cnt  = 0;
    int fall_cyc  = 0;

    logic [6:0]   a_t [N];
    logic [7:0]   r_t [N];
    logic [15:0]  w_t [N];
    logic [N-1:0] rw_v;
    logic [N-1:0] req_v;
    int           last_m  = N - 1;
    logic [15:0]  rdata_m = '0;

    // Controller: waits for en, runs a busy pulse, then idles long enough for the arbiter
    // to drop en after a final pass; if en is still high it runs the next pass.
    initial begin
        bus.i2c_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.i2c_en === 1'b1 && ctrl_live && rst === 1'b0) begin
                repeat (2) @(negedge clk);
                bus.i2c_busy = 1'b1;
                pass_cnt++;
                repeat (busy_len) @(negedge clk);
                bus.i2c_busy = 1'b0;
                fall_cyc = cyc;
                repeat (6) @(negedge clk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int predict(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[7*i +: 7]    = a_t[i];
            bus.req_reg[8*i +: 8]     = r_t[i];
            bus.req_wdata[16*i +: 16] = w_t[i];
        end
        bus.req_rw = rw_v;
        bus.req    = req_v;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            a_t[i] = 7'($urandom);
            r_t[i] = 8'($urandom);
            w_t[i] = 16'($urandom);
        end
        rw_v         = N'($urandom);
        bus.mode_cfg = 2'($urandom);
        bus.i2c_dout = 16'($urandom);
        busy_len     = int'($urandom_range(4, 10));
        apply();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_err"},   32'(bus.err), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_en"},    32'(bus.i2c_en), 32'd0);
        chk({tag, "_addr"},  32'(bus.i2c_addr), 32'd0);
        chk({tag, "_reg"},   32'(bus.i2c_reg), 32'd0);
        chk({tag, "_rw"},    32'(bus.i2c_rw), 32'd0);
        chk({tag, "_din"},   32'(bus.i2c_din), 32'd0);
    endtask

    // One full transaction for the predicted owner; returns at the negedge showing done/err.
    task automatic run_txn(input int own, input bit expect_err, input bit mutate, input string tag);
        int          n, en_low, grant_cyc, busy_seen;
        bit          unstable, gnt_bad;
        logic [6:0]  addr_x;
        logic [7:0]  reg_x;
        logic [15:0] din_x, dout_x;
        logic        rw_x;
        addr_x = a_t[own];
        reg_x  = r_t[own];
        din_x  = w_t[own];
        rw_x   = rw_v[own];
        dout_x = bus.i2c_dout;
        n = 0;
        while (bus.gnt === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        grant_cyc = cyc;
        pass_cnt  = 0;
        chk({tag, "_gnt"},  32'(bus.gnt), 32'd1 << own);
        chk({tag, "_addr"}, 32'(bus.i2c_addr), 32'(addr_x));
        chk({tag, "_reg"},  32'(bus.i2c_reg), 32'(reg_x));
        chk({tag, "_rw"},   32'(bus.i2c_rw), 32'(rw_x));
        chk({tag, "_din"},  32'(bus.i2c_din), 32'(din_x));
        chk({tag, "_mode"}, 32'(bus.i2c_mode), 32'(bus.mode_cfg));
        chk({tag, "_en0"},  32'(bus.i2c_en), 32'd0);
        @(negedge clk);
        chk({tag, "_en1"},  32'(bus.i2c_en), 32'd1);
        n = 0; en_low = -1; busy_seen = 0; unstable = 1'b0; gnt_bad = 1'b0;
        while (bus.done === '0 && bus.err === '0 && n < 600) begin
            if (bus.i2c_en !== 1'b1 && en_low < 0) en_low = cyc;
            if (bus.gnt !== N'(1 << own)) gnt_bad = 1'b1;
            if (bus.i2c_din !== din_x || bus.i2c_addr !== addr_x ||
                bus.i2c_reg !== reg_x || bus.i2c_rw !== rw_x) unstable = 1'b1;
            if (mutate && bus.i2c_busy === 1'b1) begin
                busy_seen++;
                if (busy_seen == 4) begin
                    w_t[own]   = ~din_x;
                    req_v[own] = 1'b0;
                    apply();
                end
            end
            @(negedge clk);
            n++;
        end
        if (expect_err) begin
            chk({tag, "_err"},     32'(bus.err), 32'd1 << own);
            chk({tag, "_nodone"},  32'(bus.done), 32'd0);
            chk({tag, "_err_lat"}, 32'(cyc - grant_cyc), 32'(TMO + 1));
            chk({tag, "_err_en"},  32'(bus.i2c_en), 32'd0);
        end else begin
            if (rw_x) rdata_m = dout_x;
            chk({tag, "_done"},    32'(bus.done), 32'd1 << own);
            chk({tag, "_noerr"},   32'(bus.err), 32'd0);
            chk({tag, "_passes"},  32'(pass_cnt), rw_x ? 32'd2 : 32'd1);
            chk({tag, "_en_drop"}, 32'(en_low - fall_cyc), 32'd3);
            chk({tag, "_done_lat"},32'(cyc - en_low), 32'd1);
            chk({tag, "_rdata"},   32'(bus.rdata), 32'(rdata_m));
        end
        chk({tag, "_hold"}, {30'd0, unstable, gnt_bad}, 32'd0);
        last_m = own;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_t[i] = '0; r_t[i] = '0; w_t[i] = '0;
        end
        rw_v = '0; req_v = '0;
        bus.mode_cfg = 2'd0;
        bus.i2c_dout = '0;
        apply();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write from requester 0
        a_t[0] = 7'h48; r_t[0] = 8'h01; w_t[0] = 16'hA55A; rw_v = '0;
        bus.mode_cfg = 2'd1; bus.i2c_dout = 16'hBEEF; busy_len = 6;
        req_v = 4'b0001; apply();
        run_txn(predict(req_v), 1'b0, 1'b0, "wr");
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        // two-pass read from requester 2
        a_t[2] = 7'h1D; r_t[2] = 8'h0C; w_t[2] = 16'h0000; rw_v = 4'b0100;
        bus.i2c_dout = 16'h1234; busy_len = 8;
        req_v = 4'b0100; apply();
        run_txn(predict(req_v), 1'b0, 1'b0, "rd");
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        // all requesters held high: strict rotation
        req_v = '1;
        for (int t = 0; t < 8; t++) begin
            rand_fields();
            run_txn(predict(req_v), 1'b0, 1'b0, "rr");
        end
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        // random request patterns
        for (int t = 0; t < 10; t++) begin
            req_v = N'($urandom_range(1, (1 << N) - 1));
            rand_fields();
            run_txn(predict(req_v), 1'b0, 1'b0, "rnd");
        end
        req_v = '0; apply();
        repeat (20) @(negedge clk);

        // controller never goes busy: timeout on requester 1, then a normal grant
        ctrl_live = 1'b0;
        rand_fields();
        req_v = 4'b0010; apply();
        run_txn(predict(req_v), 1'b1, 1'b0, "tmo");
        req_v = '0; apply();
        repeat (3) @(negedge clk);
        ctrl_live = 1'b1;
        rand_fields();
        req_v = 4'b0011; apply();
        run_txn(predict(req_v), 1'b0, 1'b0, "post_tmo");
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        // wdata change and req drop while the bus is running
        rand_fields();
        rw_v[0] = 1'b0;
        req_v = 4'b0001; apply();
        run_txn(predict(req_v), 1'b0, 1'b1, "mut");
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        // reset during the second pass of a read
        rand_fields();
        rw_v[3] = 1'b1;
        req_v = 4'b1000; apply();
        n = 0;
        while (bus.gnt === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rstrd_gnt", 32'(bus.gnt), 32'd1 << predict(req_v));
        pass_cnt = 0;
        n = 0;
        while (!(pass_cnt == 2 && bus.i2c_busy === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rstrd_pass2", 32'(pass_cnt), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rstrd");
        rdata_m = '0;
        last_m  = N - 1;
        req_v = '0; apply();
        repeat (20) @(negedge clk);
        rst = 1'b0;
        rand_fields();
        req_v = '1; apply();
        run_txn(predict(req_v), 1'b0, 1'b0, "post_rst");
        req_v = '0; apply();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
